// File: rtl/uart_frac_baud_gen_if.sv
// Config/tick bundle between the UART register file
// and the fractional baud generator.
interface uart_frac_baud_gen_if #(
  parameter int DIV_W  = 13,
  parameter int FRAC_W = 3,
  parameter int OSR_W  = 4
);
  logic              enable;
  logic [DIV_W-1:0]  baud_val;
  logic [FRAC_W-1:0] baud_frac;
  logic              load;
  logic              baud_clock;
  logic              xmit_pulse;
  logic [OSR_W-1:0]  osr_cnt;
  logic              cfg_pending;

  modport master (
    output enable, baud_val, baud_frac, load,
    input  baud_clock, xmit_pulse, osr_cnt,
    input  cfg_pending
  );

  modport slave (
    input  enable, baud_val, baud_frac, load,
    output baud_clock, xmit_pulse, osr_cnt,
    output cfg_pending
  );
endinterface

// File: rtl/uart_frac_baud_gen.sv
// Fractional oversampling baud tick generator with
// shadowed divisor update and synchronous restart.
module uart_frac_baud_gen #(
  parameter int DIV_W   = 13,
  parameter int FRAC_W  = 3,
  parameter int OSR_W   = 4,
  parameter int FRAC_EN = 1
) (
  input logic clk,
  input logic reset_n,
  uart_frac_baud_gen_if.slave bus
);
  localparam logic [DIV_W-1:0] ONE_D = 1;
  localparam logic [OSR_W-1:0] ONE_O = 1;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  val_q, val_d;
  logic [DIV_W-1:0]  vsh_q, vsh_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] frc_q, frc_d;
  logic [FRAC_W-1:0] fsh_q, fsh_d;
  logic [FRAC_W-1:0] frc_eff, acc_n;
  logic [OSR_W-1:0]  osr_q, osr_d;
  logic              carry, tick;
  logic              str_q, str_d;
  logic              pend_q, pend_d;
  logic              bclk_q, bclk_d;
  logic              xmit_q, xmit_d;

  assign frc_eff = (FRAC_EN != 0) ? frc_q : '0;
  assign {carry, acc_n} = {1'b0, acc_q} + {1'b0, frc_eff};

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    str_d  = str_q;
    pend_d = pend_q;
    val_d  = val_q;
    frc_d  = frc_q;
    vsh_d  = vsh_q;
    fsh_d  = fsh_q;
    osr_d  = osr_q;
    tick   = 1'b0;
    if (!bus.enable) begin
      cnt_d  = '0;
      acc_d  = '0;
      str_d  = 1'b0;
      osr_d  = '0;
      pend_d = 1'b0;
      if (bus.load) begin
        val_d = bus.baud_val;
        frc_d = bus.baud_frac;
        vsh_d = bus.baud_val;
        fsh_d = bus.baud_frac;
      end else if (pend_q) begin
        val_d = vsh_q;
        frc_d = fsh_q;
      end
    end else if (cnt_q == '0) begin
      if (!str_q) acc_d = acc_n;
      if (carry && !str_q) begin
        str_d = 1'b1;
      end else begin
        tick   = 1'b1;
        str_d  = 1'b0;
        pend_d = 1'b0;
        // a load on the tick itself bypasses the shadow
        if (bus.load) begin
          val_d = bus.baud_val;
          frc_d = bus.baud_frac;
          vsh_d = bus.baud_val;
          fsh_d = bus.baud_frac;
          acc_d = '0;
        end else if (pend_q) begin
          val_d = vsh_q;
          frc_d = fsh_q;
          acc_d = '0;
        end
        cnt_d = val_d;
        osr_d = osr_q + ONE_O;
      end
    end else begin
      cnt_d = cnt_q - ONE_D;
    end
    if (bus.enable && bus.load && !tick) begin
      vsh_d  = bus.baud_val;
      fsh_d  = bus.baud_frac;
      pend_d = 1'b1;
    end
    bclk_d = tick;
    xmit_d = tick && (osr_q == '1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      str_q  <= 1'b0;
      osr_q  <= '0;
      pend_q <= 1'b0;
      bclk_q <= 1'b0;
      xmit_q <= 1'b0;
      val_q  <= bus.baud_val;
      frc_q  <= bus.baud_frac;
      vsh_q  <= bus.baud_val;
      fsh_q  <= bus.baud_frac;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      str_q  <= str_d;
      osr_q  <= osr_d;
      pend_q <= pend_d;
      bclk_q <= bclk_d;
      xmit_q <= xmit_d;
      val_q  <= val_d;
      frc_q  <= frc_d;
      vsh_q  <= vsh_d;
      fsh_q  <= fsh_d;
    end
  end

  assign bus.baud_clock  = bclk_q;
  assign bus.xmit_pulse  = xmit_q;
  assign bus.osr_cnt     = osr_q;
  assign bus.cfg_pending = pend_q;
endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Scoreboard bench: stimulus queues expected tick times,
// per-instance monitors pop and compare on baud_clock.
module tb_uart_frac_baud_gen;
  typedef struct {
    int t;
    int x;
    int o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rst1_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   nt0, nt1;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frac_baud_gen_if #(.DIV_W(13), .FRAC_W(3), .OSR_W(4)) b0();
  uart_frac_baud_gen_if #(.DIV_W(13), .FRAC_W(3), .OSR_W(4)) b1();

  uart_frac_baud_gen #(
    .DIV_W(13), .FRAC_W(3), .OSR_W(4), .FRAC_EN(1)
  ) u0 (
    .clk(clk), .reset_n(rst_n), .bus(b0)
  );

  uart_frac_baud_gen #(
    .DIV_W(13), .FRAC_W(3), .OSR_W(4), .FRAC_EN(0)
  ) u1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
                  nm, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic exp0(input int t);
    exp_t e;
    nt0++;
    e.t = t;
    e.x = (nt0 % 16 == 0) ? 1 : 0;
    e.o = nt0 % 16;
    q0.push_back(e);
  endtask

  task automatic exp1(input int t);
    exp_t e;
    nt1++;
    e.t = t;
    e.x = (nt1 % 16 == 0) ? 1 : 0;
    e.o = nt1 % 16;
    q1.push_back(e);
  endtask

  task automatic start(input int v, input int f, output int c);
    step();
    b0.enable    = 1'b0;
    b0.load      = 1'b1;
    b0.baud_val  = 13'(v);
    b0.baud_frac = 3'(f);
    step();
    b0.load = 1'b0;
    step();
    b0.enable = 1'b1;
    nt0 = 0;
    c = cyc;
  endtask

  task automatic drain(input string nm);
    step();
    step();
    chk(nm, q0.size(), 0);
  endtask

  always @(negedge clk) begin
    if (b0.baud_clock) begin
      if (q0.size() == 0) chk("tick0_unexpected", cyc, -1);
      else begin
        e0 = q0.pop_front();
        chk("tick0_time", cyc, e0.t);
        chk("tick0_xmit", int'(b0.xmit_pulse), e0.x);
        chk("tick0_osr", int'(b0.osr_cnt), e0.o);
      end
    end else begin
      chk("xmit0_idle", int'(b0.xmit_pulse), 0);
    end
  end

  always @(negedge clk) begin
    if (b1.baud_clock) begin
      if (q1.size() == 0) chk("tick1_unexpected", cyc, -1);
      else begin
        e1 = q1.pop_front();
        chk("tick1_time", cyc, e1.t);
      end
    end
  end

  initial begin
    int c;
    rst_n        = 1'b0;
    b0.enable    = 1'b1;
    b0.load      = 1'b0;
    b0.baud_val  = 13'd3;
    b0.baud_frac = 3'd0;
    rst1_n       = 1'b0;
    b1.enable    = 1'b1;
    b1.load      = 1'b0;
    b1.baud_val  = 13'd2;
    b1.baud_frac = 3'd7;
    nt0 = 0;
    nt1 = 0;
    step();
    step();
    step();
    chk("rst_bclk", int'(b0.baud_clock), 0);
    chk("rst_xmit", int'(b0.xmit_pulse), 0);
    chk("rst_osr", int'(b0.osr_cnt), 0);
    chk("rst_pend", int'(b0.cfg_pending), 0);

    // div 3, frac 0: period 4, xmit every 64
    rst_n = 1'b1;
    c = cyc;
    for (int k = 0; k < 20; k++) exp0(c + 1 + 4 * k);
    wait_until(c + 77);
    b0.enable = 1'b0;
    drain("div3_done");

    // div 2, frac 4: periods 4,3,... sum 56 over 16
    start(2, 4, c);
    exp0(c + 1);
    for (int k = 0; k < 8; k++) begin
      exp0(c + 1 + 7 * k + 4);
      exp0(c + 1 + 7 * k + 7);
    end
    wait_until(c + 57);
    b0.enable = 1'b0;
    drain("frac4_done");

    // div 0, frac 7: seven periods of 2, one of 1
    start(0, 7, c);
    exp0(c + 1);
    for (int g = 0; g < 2; g++) begin
      for (int k = 1; k <= 7; k++) exp0(c + 1 + 15 * g + 2 * k);
      exp0(c + 1 + 15 * g + 15);
    end
    wait_until(c + 31);
    b0.enable = 1'b0;
    drain("frac7_done");

    // shadowed load mid-period
    start(9, 0, c);
    exp0(c + 1);
    exp0(c + 11);
    for (int k = 0; k < 5; k++) exp0(c + 13 + 2 * k);
    wait_until(c + 4);
    b0.load     = 1'b1;
    b0.baud_val = 13'd1;
    step();
    b0.load = 1'b0;
    chk("pend_set", int'(b0.cfg_pending), 1);
    wait_until(c + 10);
    chk("pend_hold", int'(b0.cfg_pending), 1);
    step();
    chk("pend_apply", int'(b0.cfg_pending), 0);
    wait_until(c + 21);
    b0.enable = 1'b0;
    drain("load_mid_done");

    // load on the fire cycle bypasses the shadow
    start(9, 0, c);
    exp0(c + 1);
    exp0(c + 11);
    exp0(c + 13);
    exp0(c + 15);
    wait_until(c + 10);
    b0.load     = 1'b1;
    b0.baud_val = 13'd1;
    step();
    b0.load = 1'b0;
    chk("bypass_pend0", int'(b0.cfg_pending), 0);
    step();
    chk("bypass_pend1", int'(b0.cfg_pending), 0);
    wait_until(c + 15);
    b0.enable = 1'b0;
    drain("load_fire_done");

    // enable drop mid-period for 5 clocks
    start(3, 0, c);
    exp0(c + 1);
    exp0(c + 5);
    exp0(c + 9);
    wait_until(c + 10);
    b0.enable = 1'b0;
    step();
    chk("dis_bclk", int'(b0.baud_clock), 0);
    chk("dis_xmit", int'(b0.xmit_pulse), 0);
    chk("dis_osr", int'(b0.osr_cnt), 0);
    wait_until(c + 15);
    b0.enable = 1'b1;
    nt0 = 0;
    exp0(c + 16);
    exp0(c + 20);
    exp0(c + 24);
    wait_until(c + 24);
    b0.enable = 1'b0;
    drain("reenable_done");

    // mid-period reset at osr 9, then a sub-cycle glitch
    start(3, 0, c);
    for (int k = 0; k < 9; k++) exp0(c + 1 + 4 * k);
    wait_until(c + 34);
    rst_n       = 1'b0;
    b0.load     = 1'b1;
    b0.baud_val = 13'd5;
    step();
    rst_n   = 1'b1;
    b0.load = 1'b0;
    chk("mrst_bclk", int'(b0.baud_clock), 0);
    chk("mrst_xmit", int'(b0.xmit_pulse), 0);
    chk("mrst_osr", int'(b0.osr_cnt), 0);
    chk("mrst_pend", int'(b0.cfg_pending), 0);
    nt0 = 0;
    exp0(c + 36);
    exp0(c + 42);
    exp0(c + 48);
    wait_until(c + 37);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_until(c + 48);
    b0.enable = 1'b0;
    drain("mrst_done");

    // FRAC_EN=0 instance ignores frac=7: period 3
    rst1_n = 1'b1;
    c = cyc;
    for (int k = 0; k < 10; k++) exp1(c + 1 + 3 * k);
    wait_until(c + 28);
    b1.enable = 1'b0;
    step();
    step();
    chk("nofrac_done", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_frac_baud_gen.md
Name: uart_frac_baud_gen

Overview:
- Parametrised oversampling baud-tick generator for the UART core. Sits between the register file and the TX/RX state machines.
- Generalises the fixed 13-bit/16x divider in four ways:
  - configurable divisor, fraction and oversample widths;
  - phase-accumulator fractional divide with any 2^FRAC_W resolution;
  - glitch-free run-time divisor update via a shadow register;
  - a synchronous enable/restart input.

Parameters:
- DIV_W, 13: width of integer divisor baud_val.
- FRAC_W, 3: width of fractional divisor baud_frac; fraction = baud_frac/2^FRAC_W.
- OSR_W, 4: oversample counter width; ratio = 2^OSR_W (16x default).
- FRAC_EN, 1: 0 removes the accumulator; baud_frac is ignored and acc is held at 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  run; 0 holds the generator in restart state.
- baud_val  in  DIV_W  integer divisor; tick period = baud_val+1 clocks.
- baud_frac  in  FRAC_W  fractional divisor numerator.
- load  in  1  one-cycle strobe; captures baud_val/baud_frac into the shadow registers.
- baud_clock  out  1  one-clk oversample tick.
- xmit_pulse  out  1  one-clk pulse on every 2^OSR_W-th tick.
- osr_cnt  out  OSR_W  oversample phase, counts ticks mod 2^OSR_W.
- cfg_pending  out  1  shadow holds values not yet applied.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - cnt=0, acc=0, stretch=0, osr_cnt=0.
  - baud_clock=0, xmit_pulse=0, cfg_pending=0.
  - Active and shadow registers load baud_val/baud_frac directly.
  - Reset has priority over all other inputs.
- enable=0:
  - Same clears as reset, except active/shadow registers are kept.
  - Any pending shadow is applied to active and cfg_pending clears.
- Fire cycle (enable=1, cnt==0):
  - {c,acc_n} = acc + frac_active, where c is the carry out of FRAC_W bits.
  - If stretch==0, acc<=acc_n.
  - If c==1 and stretch==0: stretch<=1, cnt holds 0, no tick.
  - Otherwise: tick; cnt<=baud_val_active (post-apply value); stretch<=0.
- Non-fire cycle: cnt<=cnt-1, no tick.
- Resulting average period = baud_val+1+baud_frac/2^FRAC_W clocks; any stretched period is exactly one clock longer.
- Tick outputs (all registered, updated on the same edge):
  - baud_clock=1 for exactly the one cycle following the tick decision.
  - osr_cnt<=osr_cnt+1 with wrap.
  - xmit_pulse=1 when the pre-increment osr_cnt was 2^OSR_W-1, so xmit_pulse=1 coincides with osr_cnt=0.
  - xmit_pulse is never high without baud_clock.
- Latency: from the first enabled cycle with cnt=0 (after reset or after enable rise), the first baud_clock is asserted 1 clk later.
- load=1:
  - shadow<=inputs, cfg_pending<=1.
  - Shadow is applied to active at the next tick and acc is cleared on apply; cfg_pending<=0 in that cycle.
  - load coincident with a tick: new values bypass into this reload, cfg_pending stays 0.
  - load during enable=0: applied immediately.
  - Repeated loads before apply: last one wins.
- baud_val=0, frac=0: baud_clock is high every cycle after the first.
- Stretch vs apply: stretch always completes before apply; active values never change mid-period.
- Width rules:
  - cnt is DIV_W bits and never underflows (the reload path takes precedence at 0).
  - acc is FRAC_W bits, modular.

Test Plan:
- FRAC_EN=1, baud_val=3, frac=0, enable=1 after reset -> first baud_clock 1 clk after reset release, then every 4 clks; xmit_pulse every 64 clks with osr_cnt=0 on it.
- baud_val=2, frac=4 -> tick periods alternate 3,4; 16 consecutive periods after the first tick sum to exactly 56 clks.
- baud_val=0, frac=7 -> 8 consecutive periods sum to 15 clks; baud_clock never exceeds one cycle wide.
- Running baud_val=9; pulse load with baud_val=1 at 4 clks past a tick -> cfg_pending=1 for 6 clks, then periods of 2; repeat with load on the fire cycle -> cfg_pending stays 0 and the next period is 2.
- Drop enable mid-period for 5 clks -> baud_clock/xmit_pulse 0 from the next cycle; osr_cnt=0; after re-enable, first tick 1 clk later.
- reset_n=0 for one clk mid-period with osr_cnt=9 -> all outputs 0 and osr_cnt=0 next cycle; a reset_n low pulse not spanning a clk edge has no effect; FRAC_EN=0 with frac=7 gives a constant baud_val+1 period.
